bec_operand_sequencer: RTL

Sits directly downstream of the LA controller, on its BEC interconnection bus. It captures the six 163-bit operands (w1, z1, w2, z2, inv_w0, d) pushed by the controller and holds them for the BEC datapath core. It then runs the key-bit handshake (ki/next_key) for NBITS steps, driving one core step per key bit, and returns the result with slv_done.

---
 rtl/bec_operand_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/bec_operand_sequencer.sv
// Captures the six BEC operands from the LA controller, then steps the core once per key bit via ki/next_key.
// Per-bit latency is L+3 cycles for a core answering in L cycles; capture is strobe-driven, with no backpressure.
module bec_operand_sequencer #(
  parameter int NBITS = 163,
  parameter int CNTW  = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             load_data,
  input  logic [2:0]       load_status,
  input  logic             trigLoad,
  input  logic [NBITS-1:0] data_in,
  input  logic             master_ena_proc,
  input  logic             ki,
  output logic             next_key,
  output logic             slv_done,
  output logic [3:0]       becStatus,
  output logic [NBITS-1:0] result_out,
  output logic [NBITS-1:0] w1,
  output logic [NBITS-1:0] z1,
  output logic [NBITS-1:0] w2,
  output logic [NBITS-1:0] z2,
  output logic [NBITS-1:0] inv_w0,
  output logic [NBITS-1:0] d,
  output logic             core_ki,
  output logic             core_start,
  input  logic             core_step_done,
  input  logic [NBITS-1:0] core_result
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LOAD   = 4'd1,
    S_STEP   = 4'd2,
    S_WAIT   = 4'd3,
    S_SHIFT  = 4'd4,
    S_SETTLE = 4'd5,
    S_FIN    = 4'd6,
    S_DONE   = 4'd7,
    S_ABORT  = 4'd8
  } state_t;

  state_t          state;
  logic            trig_q;
  logic            err;
  logic [5:0]      loaded_mask;
  logic [CNTW-1:0] cnt;
  logic            cap_en;
  logic [2:0]      code;

  assign cap_en = load_data && trigLoad && !trig_q && (state == S_IDLE || state == S_LOAD);

  always_comb begin
    code = state[2:0];
    if (state == S_ABORT) code = 3'd3;
  end

  assign becStatus = {err, code};

  // core_start and core_ki are loaded on entry to STEP so the pulse and key bit are both visible during STEP
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state       <= S_IDLE;
      trig_q      <= 1'b0;
      err         <= 1'b0;
      loaded_mask <= '0;
      cnt         <= '0;
      w1          <= '0;
      z1          <= '0;
      w2          <= '0;
      z2          <= '0;
      inv_w0      <= '0;
      d           <= '0;
      result_out  <= '0;
      next_key    <= 1'b0;
      core_start  <= 1'b0;
      core_ki     <= 1'b0;
      slv_done    <= 1'b0;
    end else begin
      trig_q     <= trigLoad;
      next_key   <= 1'b0;
      core_start <= 1'b0;

      if (cap_en) begin
        case (load_status)
          3'd0: begin w1     <= data_in; loaded_mask[0] <= 1'b1; end
          3'd1: begin z1     <= data_in; loaded_mask[1] <= 1'b1; end
          3'd2: begin w2     <= data_in; loaded_mask[2] <= 1'b1; end
          3'd3: begin z2     <= data_in; loaded_mask[3] <= 1'b1; end
          3'd4: begin inv_w0 <= data_in; loaded_mask[4] <= 1'b1; end
          3'd5: begin d      <= data_in; loaded_mask[5] <= 1'b1; end
          default: err <= 1'b1;
        endcase
      end

      case (state)
        S_IDLE: if (load_data) state <= S_LOAD;
        S_LOAD: begin
          if (master_ena_proc) begin
            if (loaded_mask == 6'h3F) begin
              state      <= S_STEP;
              core_start <= 1'b1;
              core_ki    <= ki;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_STEP: state <= S_WAIT;
        S_WAIT: begin
          if (core_step_done) begin
            state    <= S_SHIFT;
            next_key <= 1'b1;
          end else if (!master_ena_proc) begin
            state <= S_ABORT;
          end
        end
        S_SHIFT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNTW'(NBITS - 1)) state <= S_FIN;
          else                         state <= S_SETTLE;
        end
        S_SETTLE: begin
          state      <= S_STEP;
          core_start <= 1'b1;
          core_ki    <= ki;
        end
        S_FIN: begin
          result_out <= core_result;
          slv_done   <= 1'b1;
          state      <= S_DONE;
        end
        S_DONE: begin
          if (!master_ena_proc) begin
            loaded_mask <= '0;
            cnt         <= '0;
            slv_done    <= 1'b0;
            state       <= S_IDLE;
          end
        end
        S_ABORT: begin
          cnt   <= '0;
          state <= S_LOAD;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
